// File: rtl/bit_deserializer.sv
// Serial-to-parallel collector: gathers in_bit into WIDTH-bit words and holds one word on a valid/ready port.
// Optional parity frame bit enabled by defining BIT_DESERIALIZER_PARITY_CHECK_EN.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int INVERT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overrun,
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [CW-1:0]    w_idx;
  logic [CW-1:0]    w_pos;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_complete;
  logic             w_in_parity;
  logic             w_load;
  logic             w_drop;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
  logic             w_par_fail;
  assign w_in_parity = (r_state == PARITY);
`else
  assign w_in_parity = 1'b0;
`endif

  // in_start forces the current bit to be bit 0 of a fresh word.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sr_next    = r_sr;
    w_complete   = 1'b0;
    w_idx        = in_start ? '0 : r_cnt;
    w_pos        = (MSB_FIRST != 0) ? (LAST - w_idx) : w_idx;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
    w_par_fail   = 1'b0;
`endif
    if (in_valid && (in_start || !w_in_parity)) begin
      w_sr_next[w_pos] = in_bit;
      if (w_idx == LAST) begin
        w_cnt_next = '0;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
        w_state_next = PARITY;
`else
        w_state_next = IDLE;
        w_complete   = 1'b1;
`endif
      end else begin
        w_cnt_next   = w_idx + CW'(1);
        w_state_next = COLLECT;
      end
    end
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
    else if (in_valid) begin
      // Even parity: the parity bit equals the XOR of the raw data bits.
      w_cnt_next   = '0;
      w_state_next = IDLE;
      if (in_bit == ^r_sr) w_complete = 1'b1;
      else                 w_par_fail = 1'b1;
    end
`endif
    else if (in_start) begin
      w_cnt_next   = '0;
      w_state_next = IDLE;
    end
  end

  // A completed word loads when the output slot is empty or draining this cycle.
  assign w_load = w_complete && (!out_valid || out_ready);
  assign w_drop = w_complete && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sr    <= w_sr_next;
      if (w_load) begin
        out_valid <= 1'b1;
        out_data  <= (INVERT != 0) ? ~w_sr_next : w_sr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_drop) overrun <= 1'b1;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
      parity_err <= w_par_fail;
`endif
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: LSB-first/plain and MSB-first/inverted instances share one directed stream.
// A bit-list model with a one-deep expected-word queue is compared every cycle; literals pin the model.
module tb_bit_deserializer;
  localparam int W = 8;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk, rst, in_valid, in_bit, in_start, out_ready;
  logic         lsb_valid, lsb_ovr, msb_valid, msb_ovr;
  logic [W-1:0] lsb_data, msb_data;
  logic [1:0]   lsb_dbg, msb_dbg;
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
  logic lsb_perr, msb_perr;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  bit_deserializer #(.WIDTH(W), .MSB_FIRST(0), .INVERT(0)) u_lsb (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_bit(in_bit), .in_start(in_start),
    .out_valid(lsb_valid), .out_ready(out_ready), .out_data(lsb_data), .overrun(lsb_ovr),
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
    .parity_err(lsb_perr),
`endif
    .dbg_state(lsb_dbg));

  bit_deserializer #(.WIDTH(W), .MSB_FIRST(1), .INVERT(1)) u_msb (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_bit(in_bit), .in_start(in_start),
    .out_valid(msb_valid), .out_ready(out_ready), .out_data(msb_data), .overrun(msb_ovr),
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
    .parity_err(msb_perr),
`endif
    .dbg_state(msb_dbg));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: m_raw holds bits in arrival order; m_n counts bits of the current frame
  int           m_n = 0;
  logic [W-1:0] m_raw = '0;
  logic         m_ovr = 1'b0;
  logic         m_perr = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_msb_q[$];

  function automatic logic [W-1:0] msb_word(input logic [W-1:0] raw);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) r[W-1-i] = raw[i];
    return ~r;
  endfunction

  always @(posedge clk) begin
    bit done;
    if (rst) begin
      m_n = 0; m_ovr = 1'b0; m_perr = 1'b0;
      exp_q.delete(); exp_msb_q.delete();
    end else begin
      done = 1'b0;
      m_perr = 1'b0;
      if (in_valid) begin
        if (in_start) m_n = 0;
        if (m_n < W) begin
          m_raw[m_n] = in_bit;
          m_n++;
          if (m_n == W && !PAR) begin done = 1'b1; m_n = 0; end
        end else begin
          if (in_bit == ^m_raw) done = 1'b1;
          else                  m_perr = 1'b1;
          m_n = 0;
        end
      end else if (in_start) begin
        m_n = 0;
      end
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_msb_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(m_raw);
          exp_msb_q.push_back(msb_word(m_raw));
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("lsb_valid", 32'(lsb_valid), 32'(exp_q.size() != 0));
      chk("msb_valid", 32'(msb_valid), 32'(exp_q.size() != 0));
      chk("lsb_overrun", 32'(lsb_ovr), 32'(m_ovr));
      chk("msb_overrun", 32'(msb_ovr), 32'(m_ovr));
      if (exp_q.size() != 0) begin
        chk("lsb_data", 32'(lsb_data), 32'(exp_q[0]));
        chk("msb_data", 32'(msb_data), 32'(exp_msb_q[0]));
      end
`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
      chk("lsb_parity_err", 32'(lsb_perr), 32'(m_perr));
      chk("msb_parity_err", 32'(msb_perr), 32'(m_perr));
`endif
    end
  end

  // driver tasks: inputs change at a falling edge and are captured at the next rising edge
  task automatic tick(input logic v, input logic b, input logic s);
    in_valid = v; in_bit = b; in_start = s;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic start, input logic rdy_last,
                           input logic gap);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1 && !PAR) out_ready = rdy_last;
      tick(1'b1, w[i], (i == 0) ? start : 1'b0);
      if (gap && i < W - 1) tick(1'b0, 1'b1, 1'b0);
    end
    if (PAR) begin
      out_ready = rdy_last;
      tick(1'b1, ^w, 1'b0);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_bit = 1'b0; in_start = 1'b0; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cmp_on = 1'b1;
    chk("reset_valid", 32'(lsb_valid), 32'h0);
    chk("reset_data", 32'(lsb_data), 32'h0);
    chk("reset_overrun", 32'(lsb_ovr), 32'h0);

    // basic word, both bit orders
    send_word(8'h05, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", 32'(lsb_valid), 32'h1);
    chk("t1_lsb_data", 32'(lsb_data), 32'h05);
    chk("t1_msb_inv_data", 32'(msb_data), 32'h5F);
    tick(1'b0, 1'b0, 1'b0);
    chk("t1_valid_drop", 32'(lsb_valid), 32'h0);

    // overrun while the consumer stalls
    out_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    chk("ovr_held_lsb", 32'(lsb_data), 32'h11);
    chk("ovr_held_msb", 32'(msb_data), 32'h77);
    chk("ovr_flag", 32'(lsb_ovr), 32'h1);
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("ovr_drain_valid", 32'(lsb_valid), 32'h0);
    chk("ovr_sticky", 32'(lsb_ovr), 32'h1);
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // consume and load on the same edge
    out_ready = 1'b0;
    send_word(8'h33, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b1, 1'b0);
    chk("sim_valid", 32'(lsb_valid), 32'h1);
    chk("sim_data", 32'(lsb_data), 32'h44);
    chk("sim_overrun", 32'(lsb_ovr), 32'h0);
    tick(1'b0, 1'b0, 1'b0);

    // realignment with in_start mid-word
    tick(1'b1, 1'b1, 1'b0); tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b1, 1'b0);
    send_word(8'hFF, 1'b1, 1'b1, 1'b0);
    chk("align_lsb", 32'(lsb_data), 32'hFF);
    chk("align_msb", 32'(msb_data), 32'h00);
    tick(1'b0, 1'b0, 1'b0);

    // reset mid-word, with a bit presented during reset
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_valid", 32'(msb_valid), 32'h0);
    chk("rst_data", 32'(msb_data), 32'h0);
    chk("rst_overrun", 32'(msb_ovr), 32'h0);
    send_word(8'h81, 1'b0, 1'b1, 1'b0);
    chk("post_rst_lsb", 32'(lsb_data), 32'h81);
    chk("post_rst_msb", 32'(msb_data), 32'h7E);

    // in_start without a bit aborts; stalls between bits change nothing
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0, 1'b1, 1'b1);
    chk("stall_lsb", 32'(lsb_data), 32'hA5);
    chk("stall_msb", 32'(msb_data), 32'h5A);

    // back-to-back words, no bubbles
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("b2b_first", 32'(lsb_data), 32'h3C);
    send_word(8'hC3, 1'b0, 1'b1, 1'b0);
    chk("b2b_second", 32'(lsb_data), 32'hC3);
    tick(1'b0, 1'b0, 1'b0);

`ifdef BIT_DESERIALIZER_PARITY_CHECK_EN
    for (int i = 0; i < W; i++) tick(1'b1, (i < 2) ? 1'b1 : 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("par_ok_valid", 32'(lsb_valid), 32'h1);
    chk("par_ok_data", 32'(lsb_data), 32'h03);
    chk("par_ok_err", 32'(lsb_perr), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) tick(1'b1, (i < 2) ? 1'b1 : 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("par_bad_valid", 32'(lsb_valid), 32'h0);
    chk("par_bad_err", 32'(lsb_perr), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    chk("par_err_pulse", 32'(lsb_perr), 32'h0);
`endif

    tick(1'b0, 1'b0, 1'b0);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
